// File: rtl/operand_input_fifo.sv
// operand_input_fifo
//   Staging buffer for multiplicand/multiplier pairs in front of the Booth multiplier
//   core. It holds up to DEPTH pairs and hands them over in strict arrival order,
//   with a valid/ready handshake on both sides.
//
// Ports
//   clk, reset_n            clock (rising edge), asynchronous active-low reset
//   flush                   synchronous clear of all stored pairs
//   in_valid/in_ready       producer handshake; in_mcand/in_mplier carry the pair
//   out_valid/out_ready     consumer handshake; out_mcand/out_mplier show the oldest pair
//                           (both are zero when out_valid is low)
//   count, full, empty      occupancy, 0..DEPTH
//
// Configuration
//   OPFIFO_BYPASS_EN        If defined, an incoming pair is shown on the outputs in the
//                           same cycle when the buffer is empty. If the consumer takes it
//                           in that cycle, the pair passes straight through and is never
//                           written to storage.

module operand_input_fifo #(
    parameter  int unsigned WIDTH = 16,
    parameter  int unsigned DEPTH = 4,  // power of 2, >= 2
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_mcand,
    input  logic [WIDTH-1:0] in_mplier,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_mcand,
    output logic [WIDTH-1:0] out_mplier,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [2*WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q;

    logic push;     // pair written into storage
    logic pop_mem;  // oldest stored pair handed to the consumer
    logic bypass;   // empty buffer, incoming pair presented directly

    // Occupancy flags come from the count only; the pointers alone cannot tell
    // full from empty.
    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    // in_ready does not look at out_ready, so a full buffer never accepts a
    // push, even in a cycle where it pops.
    assign in_ready = !full && !flush;

`ifdef OPFIFO_BYPASS_EN
    assign bypass = empty && in_valid && !flush;
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        out_valid  = !empty || bypass;
        out_mcand  = '0;
        out_mplier = '0;
        if (!empty) begin
            {out_mcand, out_mplier} = mem_q[rd_ptr_q];
        end else if (bypass) begin
            out_mcand  = in_mcand;
            out_mplier = in_mplier;
        end
    end

    // A bypassed pair that is taken in the same cycle is never written.
    assign push    = in_valid && in_ready && !(bypass && out_ready);
    assign pop_mem = !empty && out_ready && !flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_mem) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({push, pop_mem})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage has no reset; its contents are only read when count is nonzero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_mcand, in_mplier};
        end
    end

endmodule

// File: tb/tb_operand_input_fifo.sv
module tb_operand_input_fifo;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_mcand;
    logic [WIDTH-1:0] in_mplier;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_mcand;
    logic [WIDTH-1:0] out_mplier;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;

    int checks = 0;
    int errors = 0;

    // Reference model: the pairs currently held, oldest first.
    logic [31:0] exp_q[$];

    operand_input_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mcand  (in_mcand),
        .in_mplier (in_mplier),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mcand (out_mcand),
        .out_mplier(out_mplier),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus just after the rising edge.
    task automatic drive(input logic v, input logic [15:0] mc, input logic [15:0] mp,
                         input logic ordy, input logic fl);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_mcand  = mc;
        in_mplier = mp;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    endtask

    // Monitor / scoreboard: sampled mid-cycle, compares every output against the
    // model, then applies the handshakes that will happen at the next rising edge.
    int          n;
    logic        byp;
    logic        e_valid;
    logic [31:0] e_data;
    logic        accept;

    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
        end else begin
            n   = exp_q.size();
            byp = 1'b0;
`ifdef OPFIFO_BYPASS_EN
            byp = (n == 0) && in_valid && !flush;
`endif
            e_valid = (n != 0) || byp;
            e_data  = (n != 0) ? exp_q[0] : (byp ? {in_mcand, in_mplier} : 32'h0);
            chk("count",     32'(count),               32'(n));
            chk("full",      32'(full),                32'(n == DEPTH));
            chk("empty",     32'(empty),               32'(n == 0));
            chk("in_ready",  32'(in_ready),            32'((n < DEPTH) && !flush));
            chk("out_valid", 32'(out_valid),           32'(e_valid));
            chk("out_data",  {out_mcand, out_mplier},  e_data);
            if (flush) begin
                exp_q.delete();
            end else begin
                accept = in_valid && (n < DEPTH);
                if (byp && out_ready) begin
                    accept = 1'b0;
                end else if (n != 0 && out_ready) begin
                    void'(exp_q.pop_front());
                end
                if (accept) exp_q.push_back({in_mcand, in_mplier});
            end
        end
    end

    logic [15:0] fill_mc [4];
    logic [15:0] fill_mp [4];

    initial begin
        fill_mc[0] = 16'h0003; fill_mp[0] = 16'h0005;
        fill_mc[1] = 16'h1234; fill_mp[1] = 16'hFFFF;
        fill_mc[2] = 16'h8000; fill_mp[2] = 16'h7FFF;
        fill_mc[3] = 16'h00FF; fill_mp[3] = 16'h0100;

        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_mcand = '0; in_mplier = '0;
        #23 reset_n = 1'b1;
        idle(2);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_count", 32'(count), 32'd0);

        // Fill to full, then offer a fifth pair that must be refused.
        for (int i = 0; i < 4; i++) drive(1'b1, fill_mc[i], fill_mp[i], 1'b0, 1'b0);
        drive(1'b1, 16'hDEAD, 16'hBEEF, 1'b0, 1'b0);
        #1;
        chk("fill_full",  32'(full),     32'd1);
        chk("fill_count", 32'(count),    32'd4);
        chk("fill_ready", 32'(in_ready), 32'd0);

        // Drain: the monitor checks order against the model.
        for (int i = 0; i < 4; i++) drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        #1;
        chk("drain_empty", 32'(empty),     32'd1);
        chk("drain_valid", 32'(out_valid), 32'd0);

        // Wrap: two held, then ten cycles of simultaneous push and pop.
        drive(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0);
        drive(1'b1, 16'h3333, 16'h4444, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++)
            drive(1'b1, 16'($urandom), 16'($urandom), 1'b1, 1'b0);
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        #1;
        chk("wrap_count", 32'(count), 32'd2);
        idle(1);
        for (int i = 0; i < 2; i++) drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);

        // Flush with count=3 while offering a push and a pop.
        for (int i = 0; i < 3; i++) drive(1'b1, 16'(i + 7), 16'(i + 9), 1'b0, 1'b0);
        drive(1'b1, 16'hAAAA, 16'hBBBB, 1'b1, 1'b1);
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        #1;
        chk("flush_count", 32'(count),     32'd0);
        chk("flush_valid", 32'(out_valid), 32'd0);

        // Latency from empty.
        drive(1'b1, 16'h00AA, 16'h0055, 1'b0, 1'b0);
        #1;
`ifdef OPFIFO_BYPASS_EN
        chk("lat_same_cycle", 32'(out_valid), 32'd1);
`else
        chk("lat_same_cycle", 32'(out_valid), 32'd0);
`endif
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        #1;
        chk("lat_next_valid", 32'(out_valid), 32'd1);
        chk("lat_next_data",  {out_mcand, out_mplier}, 32'h00AA_0055);
        drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
`ifdef OPFIFO_BYPASS_EN
        drive(1'b1, 16'h00AA, 16'h0055, 1'b1, 1'b0);
        #1;
        chk("byp_valid", 32'(out_valid), 32'd1);
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        #1;
        chk("byp_count", 32'(count), 32'd0);
`endif

        // Random traffic.
        for (int i = 0; i < 400; i++)
            drive(1'($urandom), 16'($urandom), 16'($urandom),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));

        // Asynchronous reset mid-run with three pairs held.
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) drive(1'b1, 16'(i + 1), 16'(i + 2), 1'b0, 1'b0);
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        #1;
        chk("pre_rst_count", 32'(count), 32'd3);
        #1;
        reset_n = 1'b0;
        #1;
        chk("arst_count",    32'(count),               32'd0);
        chk("arst_empty",    32'(empty),               32'd1);
        chk("arst_valid",    32'(out_valid),           32'd0);
        chk("arst_data",     {out_mcand, out_mplier},  32'h0);
        chk("arst_in_ready", 32'(in_ready),            32'd1);
        @(negedge clk);
        #2 reset_n = 1'b1;
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
